result_decider: RTL
===================

Name: result_decider

Overview:
- Back-end counterpart of the ALU operand selection: accepts the ALU result plus control bits for one instruction and decides where the result goes.
- Three possible outcomes: register-file write-back of the ALU result, memory store, or memory load followed by write-back of the loaded word.
- Owns the data-memory request/acknowledge handshake with a timeout, and holds the architectural flag register (carry, zero, sign).
- Sits between the ALU and the register file / data memory in the RISC datapath.

Parameters:
- DATA_W, 32, datapath and memory word width
- REG_AW, 5, register-file address width
- TIMEOUT, 15, max cycles to wait for mem_ack before abort (1..2^TO_W-1)
- TO_W, 4, timeout counter width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: instruction inputs below are valid
- alu_result  in  DATA_W  ALU output; is the memory address for loads/stores
- alu_flags  in  3  {carry, zero, sign} from ALU
- memRead  in  1  load instruction
- memWrite  in  1  store instruction
- regWrite  in  1  instruction writes a register
- flagWrite  in  1  instruction updates flags
- write_addr  in  REG_AW  destination register
- store_data  in  DATA_W  register data to store
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  DATA_W  memory address
- mem_wdata  out  DATA_W  store data
- mem_ack  in  1  memory acknowledge; mem_rdata valid when high on a read
- mem_rdata  in  DATA_W  load data
- rf_we  out  1  register-file write enable, one cycle
- rf_waddr  out  REG_AW  register-file write address
- rf_wdata  out  DATA_W  register-file write data
- flags  out  3  architectural {carry, zero, sign}
- busy  out  1  instruction in progress
- done  out  1  one-cycle completion pulse
- mem_err  out  1  one-cycle pulse on memory timeout

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs and internal registers go to 0, including flags;
  - state goes to IDLE;
  - any in-flight request is dropped immediately, with no write-back.
- All outputs are registered.
- FSM states are IDLE, MEM, WB, ERR.
- IDLE:
  - busy=0.
  - On start, latch all instruction inputs.
  - If memRead or memWrite: go to MEM, and drive mem_addr=alu_result, mem_we=(memWrite & ~memRead), mem_wdata=store_data.
  - Otherwise go to WB.
  - memRead has priority when both memRead and memWrite are set; the access is treated as a load.
- MEM:
  - mem_req=1, busy=1.
  - mem_addr, mem_we and mem_wdata stay stable until acknowledged.
  - Timeout counter is cleared on entry and increments each MEM cycle without ack.
  - On mem_ack=1: deassert mem_req next cycle; on a read, capture mem_rdata; go to WB.
  - If the counter reaches TIMEOUT without ack: drop mem_req and go to ERR.
  - An ack that arrives in the same cycle the counter reaches TIMEOUT counts as success.
- WB (one cycle):
  - rf_we = latched regWrite & ~(store instruction);
  - rf_waddr = latched write_addr;
  - rf_wdata = captured mem_rdata for loads, latched alu_result otherwise;
  - flags <= latched alu_flags if flagWrite, else unchanged;
  - done=1, busy=1;
  - then go to IDLE.
- ERR (one cycle): mem_err=1, done=1, rf_we=0, flags unchanged; then go to IDLE.
- busy is high in MEM, WB and ERR.
- start while busy is ignored; no queueing.
- start in the cycle after done is accepted.
- mem_ack while in IDLE or WB is ignored.
- Latency (start sampled in cycle N):
  - non-memory instruction: rf_we/done in cycle N+1;
  - load/store with ack in the first request cycle: mem_req in N+1, WB in N+2;
  - each extra wait cycle adds one.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, MEM=2'd1, WB=2'd2, ERR=2'd3);
  - flag bit index constants FLAG_C=2, FLAG_Z=1, FLAG_S=0;
  - default DATA_W and REG_AW.
- One natural sub-module: mem_timeout_counter (clear, enable, expired output at TIMEOUT).

Test Plan:
- ALU write-back: start with alu_result=32'h0000_00A5, regWrite=1, write_addr=7, flagWrite=1, alu_flags=3'b010 -> next cycle rf_we=1, rf_waddr=7, rf_wdata=32'hA5, done=1; flags=3'b010 from then on.
- Load with 2 wait cycles: memRead=1, alu_result=32'h40, write_addr=3, mem_ack after 2 cycles with mem_rdata=32'hDEAD_BEEF -> mem_req held 3 cycles with mem_addr=32'h40, mem_we=0; then rf_we=1, rf_waddr=3, rf_wdata=32'hDEADBEEF.
- Store: memWrite=1, alu_result=32'h80, store_data=32'h1234, regWrite=1, immediate ack -> mem_we=1, mem_wdata=32'h1234, no rf_we, done asserted 2 cycles after start.
- Timeout: memRead=1, mem_ack held 0 -> mem_req high exactly TIMEOUT (15) cycles, then mem_err=1 and done=1, rf_we never asserted, flags unchanged.
- Busy and reset: second start pulse during MEM is ignored (a single done); rst_n low mid-MEM -> mem_req=0, busy=0, flags=0 asynchronously, no rf_we after release.
- Flag hold: flagWrite=0 with alu_flags=3'b111 after flags=3'b010 -> flags stay 3'b010.

Source files
------------

// File: rtl/result_decider_pkg.sv
// result_decider_pkg: shared FSM encoding, flag bit positions and default widths
package result_decider_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_S = 0;
  typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, WB = 2'd2, ERR = 2'd3} state_e;
endpackage

// File: rtl/result_decider_timeout.sv
// mem_timeout_counter: counts un-acknowledged memory cycles; expired_o flags the cycle
// whose increment would reach TIMEOUT
module mem_timeout_counter #(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [TO_W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
  end
  assign expired_o = en_i && (cnt_q == TO_W'(TIMEOUT - 1));
endmodule

// File: rtl/result_decider.sv
// result_decider: routes an ALU result to write-back, store or load, owning the
// memory handshake with timeout and the architectural flag register
module result_decider
  import result_decider_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [2:0]        alu_flags_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              reg_write_i,
  input  logic              flag_write_i,
  input  logic [REG_AW-1:0] write_addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic [2:0]        flags_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_err_o
);
  state_e state_q, state_d;
  logic req_q, req_d, we_q, we_d, rf_we_q, rf_we_d, busy_q, busy_d;
  logic done_q, done_d, err_q, err_d, load_q, load_d, store_q, store_d;
  logic rw_q, rw_d, fw_q, fw_d, expired;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, rf_wdata_q, rf_wdata_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d, wa_q, wa_d;
  logic [2:0] flags_q, flags_d, af_q, af_d;

  mem_timeout_counter #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_to (
    .clk(clk), .rst_n(rst_n),
    .clr_i(state_q != MEM),
    .en_i(state_q == MEM && !mem_ack_i),
    .expired_o(expired)
  );

  // Write-back outputs are computed on the transition into WB so they are registered
  always_comb begin
    state_d = state_q; req_d = req_q; we_d = we_q; addr_d = addr_q; wdata_d = wdata_q;
    rf_we_d = 1'b0; rf_waddr_d = rf_waddr_q; rf_wdata_d = rf_wdata_q; flags_d = flags_q;
    done_d = 1'b0; err_d = 1'b0;
    load_d = load_q; store_d = store_q; rw_d = rw_q; fw_d = fw_q; af_d = af_q; wa_d = wa_q;
    case (state_q)
      IDLE: if (start_i) begin
        load_d = mem_read_i; store_d = mem_write_i & ~mem_read_i;
        rw_d = reg_write_i; fw_d = flag_write_i; af_d = alu_flags_i; wa_d = write_addr_i;
        if (mem_read_i || mem_write_i) begin
          state_d = MEM; req_d = 1'b1; we_d = mem_write_i & ~mem_read_i;
          addr_d = alu_result_i; wdata_d = store_data_i;
        end else begin
          state_d = WB; rf_we_d = reg_write_i; rf_waddr_d = write_addr_i;
          rf_wdata_d = alu_result_i; done_d = 1'b1;
          flags_d = flag_write_i ? alu_flags_i : flags_q;
        end
      end
      MEM: if (mem_ack_i) begin
        state_d = WB; req_d = 1'b0; rf_we_d = rw_q & ~store_q; rf_waddr_d = wa_q;
        rf_wdata_d = load_q ? mem_rdata_i : addr_q; done_d = 1'b1;
        flags_d = fw_q ? af_q : flags_q;
      end else if (expired) begin
        state_d = ERR; req_d = 1'b0; err_d = 1'b1; done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE; req_q <= 1'b0; we_q <= 1'b0; addr_q <= '0; wdata_q <= '0;
      rf_we_q <= 1'b0; rf_waddr_q <= '0; rf_wdata_q <= '0; flags_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
      load_q <= 1'b0; store_q <= 1'b0; rw_q <= 1'b0; fw_q <= 1'b0; af_q <= '0; wa_q <= '0;
    end else begin
      state_q <= state_d; req_q <= req_d; we_q <= we_d; addr_q <= addr_d; wdata_q <= wdata_d;
      rf_we_q <= rf_we_d; rf_waddr_q <= rf_waddr_d; rf_wdata_q <= rf_wdata_d; flags_q <= flags_d;
      busy_q <= busy_d; done_q <= done_d; err_q <= err_d;
      load_q <= load_d; store_q <= store_d; rw_q <= rw_d; fw_q <= fw_d; af_q <= af_d; wa_q <= wa_d;
    end
  end

  assign mem_req_o = req_q;
  assign mem_we_o = we_q;
  assign mem_addr_o = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rf_we_o = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign flags_o = flags_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign mem_err_o = err_q;
endmodule
